// File: rtl/s3g_resp_framer.sv
// s3g_resp_framer: buffers payload bytes and emits HDR, LEN, payload, CRC8 to a UART.
// Define S3G_RESP_TIMEOUT_EN to enable the 16-bit WAIT-state watchdog.
module s3g_resp_framer #(
  parameter int         MAX_LEN  = 32,
  parameter logic [7:0] HDR_BYTE = 8'hD5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_wr,
  input  logic       in_send,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] tx_data,
  output logic       tx_wr,
  input  logic       tx_done
);

  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_LEN,
    S_DATA,
    S_CRC,
    S_WAIT
  } state_t;

  state_t        state_q, state_d;
  state_t        last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [7:0]    crc_q, crc_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          tx_wr_q, tx_wr_d;
  logic [7:0]    tx_data_q, tx_data_d;

  logic [7:0]    mem_q [MAX_LEN];
  logic          mem_we;
  logic [CW-1:0] nxt_ix;
  logic [7:0]    rd_byte;

`ifdef S3G_RESP_TIMEOUT_EN
  logic [15:0]   tmo_q, tmo_d;
`endif

  // One reflected CRC8 step (poly 0x8C), LSB first
  function automatic logic [7:0] crc8_step(
    input logic [7:0] c,
    input logic [7:0] d
  );
    logic [7:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 8'h8C;
      else             r = r >> 1;
    end
    return r;
  endfunction

  // Index of the payload byte that would be issued after the current one
  always_comb begin
    nxt_ix  = (last_q == S_DATA) ? idx_q + CW'(1) : '0;
    rd_byte = mem_q[nxt_ix[AW-1:0]];
  end

  // Next-state, buffer write and registered-output computation
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    crc_d     = crc_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    tx_wr_d   = 1'b0;
    tx_data_d = tx_data_q;
    mem_we    = 1'b0;
`ifdef S3G_RESP_TIMEOUT_EN
    tmo_d     = '0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (in_wr) begin
          if (cnt_q == FULL) begin
            err_d = 1'b1;
          end else begin
            mem_we = 1'b1;
            cnt_d  = cnt_q + CW'(1);
          end
        end
        if (in_send) begin
          state_d   = S_HDR;
          last_d    = S_HDR;
          idx_d     = '0;
          busy_d    = 1'b1;
          tx_wr_d   = 1'b1;
          tx_data_d = HDR_BYTE;
        end
      end
      S_HDR, S_LEN, S_DATA, S_CRC: begin
        if (in_wr || in_send) err_d = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (in_wr || in_send) err_d = 1'b1;
        if (tx_done) begin
          unique case (last_q)
            S_HDR: begin
              state_d   = S_LEN;
              last_d    = S_LEN;
              tx_wr_d   = 1'b1;
              tx_data_d = 8'(cnt_q);
            end
            S_LEN, S_DATA: begin
              tx_wr_d = 1'b1;
              if (nxt_ix == cnt_q) begin
                state_d   = S_CRC;
                last_d    = S_CRC;
                tx_data_d = crc_q;
              end else begin
                state_d   = S_DATA;
                last_d    = S_DATA;
                idx_d     = nxt_ix;
                tx_data_d = rd_byte;
                crc_d     = crc8_step(crc_q, rd_byte);
              end
            end
            S_CRC: begin
              state_d = S_IDLE;
              last_d  = S_IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              cnt_d   = '0;
              crc_d   = 8'h00;
            end
            default: begin
              state_d = S_IDLE;
              busy_d  = 1'b0;
            end
          endcase
        end
`ifdef S3G_RESP_TIMEOUT_EN
        else if (tmo_q == 16'hFFFE) begin
          state_d = S_IDLE;
          last_d  = S_IDLE;
          busy_d  = 1'b0;
          err_d   = 1'b1;
          cnt_d   = '0;
          crc_d   = 8'h00;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
`endif
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Framer state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      last_q    <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      crc_q     <= 8'h00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      tx_wr_q   <= 1'b0;
      tx_data_q <= 8'h00;
`ifdef S3G_RESP_TIMEOUT_EN
      tmo_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      crc_q     <= crc_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      tx_wr_q   <= tx_wr_d;
      tx_data_q <= tx_data_d;
`ifdef S3G_RESP_TIMEOUT_EN
      tmo_q     <= tmo_d;
`endif
    end
  end

  // Payload buffer; contents beyond count are don't-care so no reset
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[cnt_q[AW-1:0]] <= in_data;
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign tx_wr   = tx_wr_q;
  assign tx_data = tx_data_q;

endmodule

// File: tb/tb_s3g_resp_framer.sv
// tb_s3g_resp_framer: directed bench for s3g_resp_framer.
// A UART model acks each byte and records the emitted frame.
module tb_s3g_resp_framer;

  localparam int ML = 32;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_wr;
  logic       in_send;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] tx_data;
  logic       tx_wr;
  logic       tx_done;

  always #5 clk = ~clk;

  s3g_resp_framer #(
    .MAX_LEN (ML),
    .HDR_BYTE(8'hD5)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .in_data(in_data),
    .in_wr  (in_wr),
    .in_send(in_send),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .tx_data(tx_data),
    .tx_wr  (tx_wr),
    .tx_done(tx_done)
  );

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] q[$];
  int         ndone = 0;
  int         nerr = 0;
  int         nack = 0;
  int         tviol = 0;
  bit         resp_en = 1'b1;
  bit         force_done = 1'b0;
  int         resp_dly = 2;

  int         pend = 0;
  bit         pending = 0;
  bit         prev_wr = 0;
  bit         prev_send = 0;
  bit         prev_done = 0;
  bit         cur_done = 0;
  bit         nd;
  logic [7:0] hold = 8'h00;

  // UART model: samples mid-cycle, records bytes, checks spacing/stability, acks
  initial begin
    tx_done = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (rst_n !== 1'b1) begin
        pend = 0; pending = 0; prev_wr = 0;
        prev_send = 0; prev_done = 0; cur_done = 0;
        tx_done = 1'b0;
      end else begin
        prev_done = cur_done;
        if (done === 1'b1) ndone++;
        if (err === 1'b1) nerr++;
        if (prev_done) pending = 0;
        if (tx_wr === 1'b1) begin
          q.push_back(tx_data);
          if (prev_wr || !(prev_done || prev_send)) tviol++;
          hold = tx_data;
          pending = 1;
        end else if (pending && tx_data !== hold) begin
          tviol++;
        end
        prev_wr = (tx_wr === 1'b1);
        prev_send = (in_send === 1'b1);
        nd = 0;
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            nd = 1;
            nack++;
          end
        end
        if (tx_wr === 1'b1 && resp_en) pend = resp_dly;
        if (force_done) nd = 1;
        tx_done = nd;
        cur_done = nd;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] b);
    in_data = b;
    in_wr = 1'b1;
    tick();
    in_wr = 1'b0;
  endtask

  task automatic send();
    in_send = 1'b1;
    tick();
    in_send = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok, output logic b_at);
    ok = 0;
    b_at = 1'bx;
    for (int i = 0; i < budget; i++) begin
      if (done === 1'b1) begin
        ok = 1;
        b_at = busy;
        break;
      end
      tick();
    end
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_data = 8'h00;
    in_wr = 1'b0;
    in_send = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({busy, done, err, tx_wr} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 0000", {busy, done, err, tx_wr});
    end
    n_cmp++;
    if (tx_data !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_txdata: got %h want 00", tx_data);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [7:0] exp[$];
    int ix, d0;
    bit ok;
    logic b_at;
    exp = '{8'hD5, 8'h07, 8'h76, 8'h54, 8'h81, 8'hDA, 8'h03, 8'h00, 8'h00, 8'h57};
    q.delete();
    d0 = ndone;
    wr(8'h76); wr(8'h54); wr(8'h81); wr(8'hDA);
    wr(8'h03); wr(8'h00); wr(8'h00);
    send();
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL basic_busy_n1: got %b want 1", busy);
    end
    n_cmp++;
    if ({tx_wr, tx_data} !== {1'b1, 8'hD5}) begin
      n_bad++;
      $display("FAIL basic_hdr_n1: tx_wr=%b data=%h want 1 d5", tx_wr, tx_data);
    end
    wait_done(500, ok, b_at);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL basic_done_timeout: got no done want done");
    end
    n_cmp++;
    if (b_at !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_busy_at_done: got %b want 0", b_at);
    end
    n_cmp++;
    ix = -1;
    for (int i = 0; i < exp.size(); i++)
      if (ix < 0 && (i >= q.size() || q[i] !== exp[i])) ix = i;
    if (ix < 0 && q.size() != exp.size()) ix = exp.size();
    if (ix >= 0) begin
      n_bad++;
      $display("FAIL basic_frame: byte %0d got %h (%0d bytes) want %h (%0d bytes)", ix,
               (ix < q.size()) ? q[ix] : 8'hxx, q.size(),
               (ix < exp.size()) ? exp[ix] : 8'hxx, exp.size());
    end
    n_cmp++;
    if (ndone - d0 != 1) begin
      n_bad++;
      $display("FAIL basic_done_count: got %0d want 1", ndone - d0);
    end
    n_cmp++;
    if (tviol != 0) begin
      n_bad++;
      $display("FAIL basic_tx_timing: got %0d violations want 0", tviol);
    end
  endtask

  task automatic test_short();
    logic [7:0] exp[$];
    int ix;
    bit ok;
    logic b_at;
    exp = '{8'hD5, 8'h03, 8'h76, 8'h54, 8'h81, 8'hA0};
    q.delete();
    wr(8'h76); wr(8'h54); wr(8'h81);
    send();
    wait_done(500, ok, b_at);
    n_cmp++;
    if (!ok || b_at !== 1'b0) begin
      n_bad++;
      $display("FAIL short_busy_at_done: got ok=%b busy=%b want 1 0", ok, b_at);
    end
    n_cmp++;
    ix = -1;
    for (int i = 0; i < exp.size(); i++)
      if (ix < 0 && (i >= q.size() || q[i] !== exp[i])) ix = i;
    if (ix < 0 && q.size() != exp.size()) ix = exp.size();
    if (ix >= 0) begin
      n_bad++;
      $display("FAIL short_frame: byte %0d got %h (%0d bytes) want %h (%0d bytes)", ix,
               (ix < q.size()) ? q[ix] : 8'hxx, q.size(),
               (ix < exp.size()) ? exp[ix] : 8'hxx, exp.size());
    end
  endtask

  task automatic test_stray_done();
    q.delete();
    force_done = 1'b1;
    tick();
    force_done = 1'b0;
    repeat (4) tick();
    n_cmp++;
    if (q.size() != 0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL stray_done: got %0d bytes busy=%b want 0 bytes busy=0", q.size(), busy);
    end
  endtask

  task automatic test_empty();
    logic [7:0] exp[$];
    int ix;
    bit ok;
    logic b_at;
    exp = '{8'hD5, 8'h00, 8'h00};
    q.delete();
    send();
    wait_done(500, ok, b_at);
    n_cmp++;
    ix = -1;
    for (int i = 0; i < exp.size(); i++)
      if (ix < 0 && (i >= q.size() || q[i] !== exp[i])) ix = i;
    if (ix < 0 && q.size() != exp.size()) ix = exp.size();
    if (!ok || ix >= 0) begin
      n_bad++;
      $display("FAIL empty_frame: done=%b byte %0d got %h (%0d bytes) want %h (%0d bytes)", ok, ix,
               (ix >= 0 && ix < q.size()) ? q[ix] : 8'hxx, q.size(),
               (ix >= 0 && ix < exp.size()) ? exp[ix] : 8'hxx, exp.size());
    end
  endtask

  task automatic test_overflow();
    logic [7:0] exp[$];
    int ix, e0;
    bit ok;
    logic b_at;
    exp = '{8'hD5, 8'(ML)};
    for (int i = 0; i < ML; i++) exp.push_back(8'h00);
    exp.push_back(8'h00);
    q.delete();
    e0 = nerr;
    for (int i = 0; i < ML + 1; i++) wr(8'h00);
    tick();
    tick();
    n_cmp++;
    if (nerr - e0 != 1) begin
      n_bad++;
      $display("FAIL overflow_err: got %0d want 1", nerr - e0);
    end
    send();
    wait_done(1000, ok, b_at);
    n_cmp++;
    ix = -1;
    for (int i = 0; i < exp.size(); i++)
      if (ix < 0 && (i >= q.size() || q[i] !== exp[i])) ix = i;
    if (ix < 0 && q.size() != exp.size()) ix = exp.size();
    if (!ok || ix >= 0) begin
      n_bad++;
      $display("FAIL overflow_frame: done=%b byte %0d got %h (%0d bytes) want %h (%0d bytes)", ok, ix,
               (ix >= 0 && ix < q.size()) ? q[ix] : 8'hxx, q.size(),
               (ix >= 0 && ix < exp.size()) ? exp[ix] : 8'hxx, exp.size());
    end
  endtask

  task automatic test_busy_drop();
    logic [7:0] exp[$];
    int ix, e0;
    bit ok;
    logic b_at;
    exp = '{8'hD5, 8'h03, 8'h76, 8'h54, 8'h81, 8'hA0};
    q.delete();
    wr(8'h76); wr(8'h54); wr(8'h81);
    e0 = nerr;
    send();
    tick();
    wr(8'hFF);
    tick();
    send();
    tick();
    wr(8'hEE);
    wait_done(500, ok, b_at);
    n_cmp++;
    if (nerr - e0 != 3) begin
      n_bad++;
      $display("FAIL busy_drop_err: got %0d want 3", nerr - e0);
    end
    n_cmp++;
    ix = -1;
    for (int i = 0; i < exp.size(); i++)
      if (ix < 0 && (i >= q.size() || q[i] !== exp[i])) ix = i;
    if (ix < 0 && q.size() != exp.size()) ix = exp.size();
    if (!ok || ix >= 0) begin
      n_bad++;
      $display("FAIL busy_drop_frame: done=%b byte %0d got %h (%0d bytes) want %h (%0d bytes)", ok, ix,
               (ix >= 0 && ix < q.size()) ? q[ix] : 8'hxx, q.size(),
               (ix >= 0 && ix < exp.size()) ? exp[ix] : 8'hxx, exp.size());
    end
  endtask

  task automatic test_same_cycle();
    logic [7:0] exp[$];
    int ix;
    bit ok;
    logic b_at;
    exp = '{8'hD5, 8'h03, 8'h76, 8'h54, 8'h81, 8'hA0};
    q.delete();
    wr(8'h76); wr(8'h54);
    in_data = 8'h81;
    in_wr = 1'b1;
    in_send = 1'b1;
    tick();
    in_wr = 1'b0;
    in_send = 1'b0;
    wait_done(500, ok, b_at);
    n_cmp++;
    ix = -1;
    for (int i = 0; i < exp.size(); i++)
      if (ix < 0 && (i >= q.size() || q[i] !== exp[i])) ix = i;
    if (ix < 0 && q.size() != exp.size()) ix = exp.size();
    if (!ok || ix >= 0) begin
      n_bad++;
      $display("FAIL same_cycle_frame: done=%b byte %0d got %h (%0d bytes) want %h (%0d bytes)", ok, ix,
               (ix >= 0 && ix < q.size()) ? q[ix] : 8'hxx, q.size(),
               (ix >= 0 && ix < exp.size()) ? exp[ix] : 8'hxx, exp.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp[$];
    int ix, a0;
    bit ok, hit, bb;
    logic b_at;
    q.delete();
    wr(8'h76); wr(8'h54); wr(8'h81);
    a0 = nack;
    send();
    hit = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #3;
      if (nack - a0 >= 2) begin
        hit = 1;
        break;
      end
    end
    n_cmp++;
    if (!hit) begin
      n_bad++;
      $display("FAIL reset_mid_len_ack: got %0d acks want 2", nack - a0);
    end
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    bb = 0;
    repeat (10) begin
      tick();
      if (busy !== 1'b0 || tx_wr !== 1'b0) bb = 1;
    end
    n_cmp++;
    if (bb) begin
      n_bad++;
      $display("FAIL reset_mid_quiet: got busy/tx_wr activity want none");
    end
    exp = '{8'hD5, 8'h03};
    n_cmp++;
    ix = -1;
    for (int i = 0; i < exp.size(); i++)
      if (ix < 0 && (i >= q.size() || q[i] !== exp[i])) ix = i;
    if (ix < 0 && q.size() != exp.size()) ix = exp.size();
    if (ix >= 0) begin
      n_bad++;
      $display("FAIL reset_mid_partial: byte %0d got %h (%0d bytes) want %h (%0d bytes)", ix,
               (ix < q.size()) ? q[ix] : 8'hxx, q.size(),
               (ix < exp.size()) ? exp[ix] : 8'hxx, exp.size());
    end
    exp = '{8'hD5, 8'h03, 8'h76, 8'h54, 8'h81, 8'hA0};
    q.delete();
    wr(8'h76); wr(8'h54); wr(8'h81);
    send();
    wait_done(500, ok, b_at);
    n_cmp++;
    ix = -1;
    for (int i = 0; i < exp.size(); i++)
      if (ix < 0 && (i >= q.size() || q[i] !== exp[i])) ix = i;
    if (ix < 0 && q.size() != exp.size()) ix = exp.size();
    if (!ok || ix >= 0) begin
      n_bad++;
      $display("FAIL reset_mid_frame: done=%b byte %0d got %h (%0d bytes) want %h (%0d bytes)", ok, ix,
               (ix >= 0 && ix < q.size()) ? q[ix] : 8'hxx, q.size(),
               (ix >= 0 && ix < exp.size()) ? exp[ix] : 8'hxx, exp.size());
    end
  endtask

`ifdef S3G_RESP_TIMEOUT_EN
  task automatic test_timeout();
    logic [7:0] exp[$];
    int ix, k, d0;
    bit ok;
    logic b_at;
    q.delete();
    wr(8'h42);
    resp_en = 1'b0;
    d0 = ndone;
    send();
    k = 0;
    while (k < 70000 && err !== 1'b1) begin
      tick();
      k++;
    end
    n_cmp++;
    if (k < 65534 || k > 65537) begin
      n_bad++;
      $display("FAIL timeout_err_time: got %0d cycles want 65534..65537", k);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_busy: got %b want 0", busy);
    end
    tick();
    tick();
    n_cmp++;
    if (ndone != d0) begin
      n_bad++;
      $display("FAIL timeout_no_done: got %0d want 0", ndone - d0);
    end
    resp_en = 1'b1;
    exp = '{8'hD5, 8'h00, 8'h00};
    q.delete();
    send();
    wait_done(500, ok, b_at);
    n_cmp++;
    ix = -1;
    for (int i = 0; i < exp.size(); i++)
      if (ix < 0 && (i >= q.size() || q[i] !== exp[i])) ix = i;
    if (ix < 0 && q.size() != exp.size()) ix = exp.size();
    if (!ok || ix >= 0) begin
      n_bad++;
      $display("FAIL timeout_cleared_frame: done=%b byte %0d got %h (%0d bytes) want %h", ok, ix,
               (ix >= 0 && ix < q.size()) ? q[ix] : 8'hxx, q.size(),
               (ix >= 0 && ix < exp.size()) ? exp[ix] : 8'hxx);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_short();
    test_stray_done();
    test_empty();
    test_overflow();
    test_busy_drop();
    test_same_cycle();
    test_reset_mid();
`ifdef S3G_RESP_TIMEOUT_EN
    test_timeout();
`endif
    n_cmp++;
    if (tviol != 0) begin
      n_bad++;
      $display("FAIL tx_timing_all: got %0d violations want 0", tviol);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
